mmcsr_v2_slave: RTL and testbench
=================================

MMCSR_V2_SLAVE -- requirements
Module: mmcsr_v2_slave

Interface
REQ-001 Parameter DATA_W, 32, register and AXI data width; legal values are 32 or 64.
REQ-002 Parameter ADDR_W, 8, AXI address width.
REQ-003 Parameter N_REGS, 4, number of registers; legal range 1..2**(ADDR_W-log2(DATA_W/8)).
REQ-004 Parameter RO_MASK, 0, N_REGS-bit vector; bit i=1 makes register i read-only and hardware-sourced.
REQ-005 Port clock, input, 1, sole clock; all logic is rising-edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Ports S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, AXI4-Lite write address channel; AWADDR is ADDR_W bits and AWPROT is ignored.
REQ-008 Ports S_AXI_WDATA/WSTRB/WVALID/WREADY, AXI4-Lite write data channel; WDATA is DATA_W bits and WSTRB is DATA_W/8 bits.
REQ-009 Ports S_AXI_BRESP/BVALID/BREADY, AXI4-Lite write response channel.
REQ-010 Ports S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, AXI4-Lite read address channel; ARPROT is ignored.
REQ-011 Ports S_AXI_RDATA/RRESP/RVALID/RREADY, AXI4-Lite read data channel.
REQ-012 Port csr_q, output, N_REGS*DATA_W, current register contents; register i occupies bits [i*DATA_W +: DATA_W].
REQ-013 Port csr_wr_pulse, output, N_REGS, one-cycle strobe per register on each accepted write.
REQ-014 Port hw_in, input, N_REGS*DATA_W, read value for registers with RO_MASK=1.

Function
REQ-015 Register index SHALL be addr[ADDR_W-1:log2(DATA_W/8)]; the low address bits are ignored.
REQ-016 Write FSM states SHALL be IDLE, HAVE_AW, HAVE_W, RESP; AW and W may arrive in either order or in the same cycle.
REQ-017 AWREADY SHALL be high only in IDLE or HAVE_W; WREADY SHALL be high only in IDLE or HAVE_AW; address and data are latched on handshake.
REQ-018 When both address and data are held, the write SHALL commit on the next edge with per-byte WSTRB masking, and the FSM SHALL enter RESP with BVALID=1 at that edge (AW+W in cycle T gives BVALID in T+1).
REQ-019 BVALID SHALL hold until BREADY=1; the FSM then returns to IDLE, and the next AW/W may be accepted in the following cycle.
REQ-020 Writes to RO registers SHALL leave storage unchanged, raise no csr_wr_pulse, and return BRESP=OKAY.
REQ-021 csr_wr_pulse[i] SHALL be high exactly in the commit cycle of a write to a writable in-range register i.
REQ-022 Read FSM states SHALL be IDLE and RESP; ARREADY SHALL be high only in IDLE; AR handshake in cycle T gives RVALID in T+1.
REQ-023 RDATA SHALL be captured at AR acceptance, from hw_in for RO registers and storage otherwise, and SHALL be held stable until RREADY.
REQ-024 A read and a write to the same register committing in the same cycle: the read SHALL return the pre-write value.
REQ-025 The read and write paths SHALL be fully independent and concurrent.
REQ-026 Out-of-range index (index >= N_REGS): writes SHALL have no effect and reads SHALL return 0; the response code is set by REQ-031.

Reset
REQ-027 On reset: all storage, csr_q, csr_wr_pulse, BVALID, RVALID, RDATA, BRESP and RRESP SHALL be 0.
REQ-028 On reset: both FSMs SHALL go to IDLE, and AWREADY, WREADY and ARREADY SHALL be 0 during reset and 1 in the first cycle after it.
REQ-029 Reset during an in-flight transaction SHALL discard it without completing the commit or the response.

Configuration
REQ-030 Macro MMCSR_V2_SLVERR_EN SHALL select decode-error reporting.
REQ-031 With MMCSR_V2_SLVERR_EN defined, out-of-range accesses SHALL return BRESP/RRESP=2'b10 (SLVERR); without it they SHALL return 2'b00 (OKAY); in-range behaviour is identical in both builds.

Verification
REQ-032 Bench SHALL write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read them back -> 1,2,3,4 with OKAY; csr_wr_pulse fires once per register.
REQ-033 Bench SHALL write 0xAABBCCDD with WSTRB=4'b0101 to 0x0 (old value 0x11223344) -> read 0x11BB33DD.
REQ-034 Bench SHALL present W two cycles before AW, hold BREADY=0 for 3 cycles, and check -> single commit, BVALID held 3 cycles, and AWREADY/WREADY low until the B handshake.
REQ-035 Bench SHALL build with N_REGS=4 and RO_MASK=4'b0010, drive hw_in[1]=0x5A5A5A5A, and write 0xFFFFFFFF to 0x4 -> read 0x5A5A5A5A, no csr_wr_pulse[1].
REQ-036 Bench SHALL read 0x10 with N_REGS=4 -> RDATA=0 with RRESP=SLVERR when MMCSR_V2_SLVERR_EN is defined and RRESP=OKAY otherwise.
REQ-037 Bench SHALL assert reset during the RESP state (BVALID=1) -> BVALID=0 on the next edge and all csr_q=0.

Source files
------------

// File: rtl/mmcsr_v2_slave.sv
// AXI4-Lite CSR slave: N_REGS registers with optional read-only, hardware-sourced entries.
// Define MMCSR_V2_SLVERR_EN to report out-of-range accesses with SLVERR instead of OKAY.
module mmcsr_v2_slave #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 8,
  parameter int                N_REGS  = 4,
  parameter logic [N_REGS-1:0] RO_MASK = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [DATA_W-1:0]        S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]      S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [DATA_W-1:0]        S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [N_REGS*DATA_W-1:0] csr_q,
  output logic [N_REGS-1:0]        csr_wr_pulse,
  input  logic [N_REGS*DATA_W-1:0] hw_in
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef MMCSR_V2_SLVERR_EN
  localparam logic [1:0] RESP_DEC = 2'b10;
`else
  localparam logic [1:0] RESP_DEC = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    return res;
  endfunction

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < N_REGS;
  endfunction

  logic [DATA_W-1:0] regs [N_REGS];

  // ---------------- write path ----------------
  wstate_t           wstate, wstate_nxt;
  logic              aw_hs, w_hs, commit;
  logic [ADDR_W-1:0] aw_addr_q, w_addr_cur;
  logic [DATA_W-1:0] w_data_q, w_data_cur;
  logic [STRB_W-1:0] w_strb_q, w_strb_cur;
  logic [IDX_W-1:0]  w_idx;

  assign S_AXI_AWREADY = ~reset & ((wstate == W_IDLE) | (wstate == W_HAVE_W));
  assign S_AXI_WREADY  = ~reset & ((wstate == W_IDLE) | (wstate == W_HAVE_AW));
  assign S_AXI_BVALID  = (wstate == W_RESP);
  assign aw_hs         = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID & S_AXI_WREADY;
  assign w_idx         = w_addr_cur[ADDR_W-1:LSB];

  always_ff @(posedge clock) begin
    if (reset) wstate <= W_IDLE;
    else       wstate <= wstate_nxt;
  end

  // Whichever half arrived earlier comes from its latch; the other is taken live off the bus.
  always_comb begin
    wstate_nxt = wstate;
    commit     = 1'b0;
    w_addr_cur = (wstate == W_HAVE_AW) ? aw_addr_q : S_AXI_AWADDR;
    w_data_cur = (wstate == W_HAVE_W)  ? w_data_q  : S_AXI_WDATA;
    w_strb_cur = (wstate == W_HAVE_W)  ? w_strb_q  : S_AXI_WSTRB;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end else if (aw_hs) begin
          wstate_nxt = W_HAVE_AW;
        end else if (w_hs) begin
          wstate_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
    if (w_hs) begin
      w_data_q <= S_AXI_WDATA;
      w_strb_q <= S_AXI_WSTRB;
    end
  end

  // RO entries are never written, so their storage stays at the reset value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      csr_wr_pulse <= '0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      csr_wr_pulse <= '0;
      if (commit) begin
        S_AXI_BRESP <= idx_in_range(w_idx) ? RESP_OKAY : RESP_DEC;
        for (int i = 0; i < N_REGS; i++) begin
          if (int'(w_idx) == i && !RO_MASK[i]) begin
            regs[i]         <= strb_merge(regs[i], w_data_cur, w_strb_cur);
            csr_wr_pulse[i] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_q
    assign csr_q[g*DATA_W +: DATA_W] = regs[g];
  end

  // ---------------- read path ----------------
  rstate_t           rstate, rstate_nxt;
  logic              ar_hs;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] rd_val;

  assign S_AXI_ARREADY = ~reset & (rstate == R_IDLE);
  assign S_AXI_RVALID  = (rstate == R_RESP);
  assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_idx         = S_AXI_ARADDR[ADDR_W-1:LSB];

  always_ff @(posedge clock) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_RESP;
      R_RESP:  if (S_AXI_RREADY) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Storage is sampled before any same-edge write lands, so a colliding read sees the old value.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_REGS; i++)
      if (int'(r_idx) == i) rd_val = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : regs[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RDATA <= rd_val;
      S_AXI_RRESP <= idx_in_range(r_idx) ? RESP_OKAY : RESP_DEC;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_addr_cur[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

endmodule

// File: tb/tb_mmcsr_v2_slave.sv
// Bench for mmcsr_v2_slave: a fully writable instance and one with register 1 read-only,
// both driven from one AXI stimulus and checked against an array-based register model.
module tb_mmcsr_v2_slave;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic [127:0] hw_in;

  logic [1:0]   awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp0, bresp1, rresp0, rresp1;
  logic [31:0]  rdata0, rdata1;
  logic [127:0] q0, q1;
  logic [3:0]   p0, p1;

  always #5 clock = ~clock;

  mmcsr_v2_slave #(.DATA_W(32), .ADDR_W(8), .N_REGS(4), .RO_MASK(4'b0000)) dut_rw (
    .clock(clock), .reset(reset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready[0]),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready[0]),
    .S_AXI_BRESP(bresp0), .S_AXI_BVALID(bvalid[0]), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready[0]),
    .S_AXI_RDATA(rdata0), .S_AXI_RRESP(rresp0), .S_AXI_RVALID(rvalid[0]), .S_AXI_RREADY(rready),
    .csr_q(q0), .csr_wr_pulse(p0), .hw_in(hw_in));

  mmcsr_v2_slave #(.DATA_W(32), .ADDR_W(8), .N_REGS(4), .RO_MASK(4'b0010)) dut_ro (
    .clock(clock), .reset(reset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready[1]),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready[1]),
    .S_AXI_BRESP(bresp1), .S_AXI_BVALID(bvalid[1]), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready[1]),
    .S_AXI_RDATA(rdata1), .S_AXI_RRESP(rresp1), .S_AXI_RVALID(rvalid[1]), .S_AXI_RREADY(rready),
    .csr_q(q1), .csr_wr_pulse(p1), .hw_in(hw_in));

`ifdef MMCSR_V2_SLVERR_EN
  localparam logic [1:0] DEC = 2'b10;
`else
  localparam logic [1:0] DEC = 2'b00;
`endif
  localparam logic [3:0] RO1 = 4'b0010;

  logic [31:0] mreg [2][4];
  int          pcnt [2][4];
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    bit          rd;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit is_ro(int k, int r);
    return (k == 1) && RO1[r];
  endfunction

  function automatic int idx_of(logic [7:0] a);
    return int'(a) / 4;
  endfunction

  function automatic logic [31:0] model_rd(int k, logic [7:0] a);
    int idx = idx_of(a);
    if (idx >= 4) return 32'h0;
    if (is_ro(k, idx)) return hw_in[idx*32 +: 32];
    return mreg[k][idx];
  endfunction

  function automatic logic [1:0] model_resp(logic [7:0] a);
    return (idx_of(a) >= 4) ? DEC : 2'b00;
  endfunction

  task automatic model_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = idx_of(a);
    if (idx < 4)
      for (int k = 0; k < 2; k++)
        if (!is_ro(k, idx))
          for (int b = 0; b < 4; b++)
            if (s[b]) mreg[k][idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic clr_pulses();
    for (int k = 0; k < 2; k++) for (int r = 0; r < 4; r++) pcnt[k][r] = 0;
  endtask

  task automatic sample_pulses();
    for (int r = 0; r < 4; r++) begin
      pcnt[0][r] += int'(p0[r]);
      pcnt[1][r] += int'(p1[r]);
    end
  endtask

  task automatic chk_pulses(input logic [7:0] a, input string nm);
    int idx = idx_of(a);
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 4; r++)
        chk($sformatf("%s_pulse%0d_%0d", nm, k, r), pcnt[k][r],
            (idx == r && !is_ro(k, r)) ? 1 : 0);
  endtask

  task automatic chk_q(input string nm);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("%s_q0_%0d", nm, r), q0[r*32 +: 32], mreg[0][r]);
      chk($sformatf("%s_q1_%0d", nm, r), q1[r*32 +: 32], mreg[1][r]);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input string nm);
    int n = 0;
    bit awd = 0, wd = 0;
    clr_pulses();
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(awd && wd) && n < 20) begin
      if (awready[0] && awvalid) awd = 1;
      if (wready[0] && wvalid) wd = 1;
      @(negedge clock); n++;
      sample_pulses();
      if (awd) awvalid = 1'b0;
      if (wd) wvalid = 1'b0;
    end
    chk({nm, "_addr_data_timeout"}, n < 20, 1'b1);
    n = 0;
    while (!bvalid[0] && n < 20) begin
      @(negedge clock); n++;
      sample_pulses();
    end
    chk({nm, "_bvalid_timeout"}, n < 20, 1'b1);
    chk({nm, "_bresp0"}, bresp0, model_resp(a));
    chk({nm, "_bresp1"}, bresp1, model_resp(a));
    @(negedge clock);
    sample_pulses();
    awvalid = 1'b0; wvalid = 1'b0;
    model_wr(a, d, s);
    chk_pulses(a, nm);
    chk_q(nm);
  endtask

  task automatic do_read(input logic [7:0] a, input string nm, output logic [31:0] r0, output logic [31:0] r1);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready[0] && n < 20) begin
      @(negedge clock); n++;
    end
    chk({nm, "_arready_timeout"}, n < 20, 1'b1);
    @(negedge clock);
    arvalid = 1'b0;
    chk({nm, "_rvalid_latency"}, rvalid, 2'b11);
    chk({nm, "_rdata0"}, rdata0, model_rd(0, a));
    chk({nm, "_rdata1"}, rdata1, model_rd(1, a));
    chk({nm, "_rresp0"}, rresp0, model_resp(a));
    chk({nm, "_rresp1"}, rresp1, model_resp(a));
    r0 = rdata0; r1 = rdata1;
    @(negedge clock);
    chk({nm, "_rvalid_drop"}, rvalid, 2'b00);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1, old;
    tbl.push_back('{1'b0, 8'h00, 32'h0000_0001, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 8'h04, 32'h0000_0002, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 8'h08, 32'h0000_0003, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 8'h0C, 32'h0000_0004, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 8'h00, 32'h0, 4'h0, 32'h0000_0001});
    tbl.push_back('{1'b1, 8'h04, 32'h0, 4'h0, 32'h0000_0002});
    tbl.push_back('{1'b1, 8'h08, 32'h0, 4'h0, 32'h0000_0003});
    tbl.push_back('{1'b1, 8'h0C, 32'h0, 4'h0, 32'h0000_0004});
    tbl.push_back('{1'b0, 8'h00, 32'h1122_3344, 4'hF, 32'h0});
    tbl.push_back('{1'b0, 8'h00, 32'hAABB_CCDD, 4'b0101, 32'h0});
    tbl.push_back('{1'b1, 8'h00, 32'h0, 4'h0, 32'h11BB_33DD});
    tbl.push_back('{1'b0, 8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 8'h04, 32'h0, 4'h0, 32'hFFFF_FFFF});
    tbl.push_back('{1'b1, 8'h10, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b0, 8'h11, 32'hDEAD_BEEF, 4'hF, 32'h0});
    tbl.push_back('{1'b1, 8'h12, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{1'b1, 8'h02, 32'h0, 4'h0, 32'h11BB_33DD});

    for (int k = 0; k < 2; k++) for (int r = 0; r < 4; r++) mreg[k][r] = '0;
    hw_in = {$urandom, $urandom, 32'h5A5A_5A5A, $urandom};
    awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    reset = 1'b1;

    repeat (2) @(negedge clock);
    chk("rst_readies", {awready, wready, arready}, 6'b0);
    chk("rst_valids", {bvalid, rvalid}, 4'b0);
    chk("rst_resp", {bresp0, bresp1, rresp0, rresp1}, 8'b0);
    chk("rst_rdata", {rdata0, rdata1}, 64'b0);
    chk("rst_q", {q0, q1}, 256'b0);
    chk("rst_pulse", {p0, p1}, 8'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_readies", {awready, wready, arready}, 6'b111111);
    @(negedge clock);

    foreach (tbl[i]) begin
      if (tbl[i].rd) begin
        do_read(tbl[i].a, $sformatf("vec%0d", i), r0, r1);
        chk($sformatf("vec%0d_table_rdata", i), r0, tbl[i].exp);
      end else begin
        do_write(tbl[i].a, tbl[i].d, tbl[i].s, $sformatf("vec%0d", i));
      end
    end

    do_read(8'h04, "ro_read", r0, r1);
    chk("ro_read_hw", r1, 32'h5A5A_5A5A);
    do_read(8'h10, "oor_read", r0, r1);
    chk("oor_rresp", rresp0, DEC);
    chk("oor_rdata", r0, 32'h0);

    // W leads AW by two cycles, then BREADY is withheld for three cycles.
    clr_pulses();
    bready = 1'b0; rready = 1'b1;
    awaddr = 8'h08; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clock); sample_pulses(); wvalid = 1'b0;
    chk("havew_ready", {awready, wready}, 4'b1100);
    @(negedge clock); sample_pulses();
    chk("havew_ready2", {awready, wready, bvalid}, 6'b110000);
    awvalid = 1'b1;
    @(negedge clock); sample_pulses(); awvalid = 1'b0;
    model_wr(8'h08, 32'hCAFE_F00D, 4'hF);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bhold_bvalid_%0d", c), bvalid, 2'b11);
      chk($sformatf("bhold_ready_%0d", c), {awready, wready}, 4'b0);
      if (c < 2) begin @(negedge clock); sample_pulses(); end
    end
    bready = 1'b1;
    @(negedge clock); sample_pulses();
    chk("bhold_release", {bvalid, awready, wready}, 6'b001111);
    chk_pulses(8'h08, "bhold");
    chk_q("bhold");

    // Read and write of the same register accepted together: read sees the old value.
    old = model_rd(0, 8'h08);
    awaddr = 8'h08; wdata = 32'h1357_2468; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h08; arvalid = 1'b1;
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_valids", {bvalid, rvalid}, 4'b1111);
    chk("coll_rdata_old", rdata0, old);
    model_wr(8'h08, 32'h1357_2468, 4'hF);
    @(negedge clock);
    do_read(8'h08, "coll_after", r0, r1);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 19));
      if ($urandom_range(0, 1) == 1) do_read(a, $sformatf("rnd%0d", i), r0, r1);
      else do_write(a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
    end

    // Reset while a write response is pending.
    bready = 1'b0;
    awaddr = 8'h0C; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("rstresp_bvalid", bvalid, 2'b11);
    reset = 1'b1;
    #1;
    chk("rstresp_readies_low", {awready, wready, arready}, 6'b0);
    @(negedge clock);
    chk("rstresp_bvalid_cleared", bvalid, 2'b00);
    chk("rstresp_q_cleared", {q0, q1}, 256'b0);
    reset = 1'b0;
    bready = 1'b1;
    #1;
    chk("rstresp_readies_back", {awready, wready, arready}, 6'b111111);
    for (int k = 0; k < 2; k++) for (int r = 0; r < 4; r++) mreg[k][r] = '0;
    @(negedge clock);
    do_read(8'h0C, "after_rst", r0, r1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
